// File: rtl/ps2_apple1_kbd.sv
// PS/2 set-2 keyboard front end for the Apple-1: receives frames and tracks modifiers.
// Translates make codes to upper-case ASCII held in a one-entry buffer with a sticky strobe.
module ps2_apple1_kbd #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 14318
) (
  input  logic       clk14,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       key_ack,
  output logic [6:0] key_data,
  output logic       key_strobe,
  output logic       key_overrun,
  output logic       reset_req,
  output logic       cls_req,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  logic          clk_meta, clk_sync, din_meta, din_sync;
  logic          clk_filt, sample;
  logic [FW-1:0] filt_cnt;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, rx_byte;
  logic          par_bit, byte_valid;
  logic [TW-1:0] idle_cnt;
  logic          ext, brk, shift, ctrl;
  logic [7:0]    xl;
  logic [6:0]    key_raw, key_val;
  logic          key_hit, key_take;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Result is {valid, ascii}; a clear valid bit means the code has no mapping.
  function automatic logic [7:0] xlat(input logic [7:0] code, input logic shifted);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h1C: r = 8'hC1;  8'h32: r = 8'hC2;  8'h21: r = 8'hC3;  8'h23: r = 8'hC4;
      8'h24: r = 8'hC5;  8'h2B: r = 8'hC6;  8'h34: r = 8'hC7;  8'h33: r = 8'hC8;
      8'h43: r = 8'hC9;  8'h3B: r = 8'hCA;  8'h42: r = 8'hCB;  8'h4B: r = 8'hCC;
      8'h3A: r = 8'hCD;  8'h31: r = 8'hCE;  8'h44: r = 8'hCF;  8'h4D: r = 8'hD0;
      8'h15: r = 8'hD1;  8'h2D: r = 8'hD2;  8'h1B: r = 8'hD3;  8'h2C: r = 8'hD4;
      8'h3C: r = 8'hD5;  8'h2A: r = 8'hD6;  8'h1D: r = 8'hD7;  8'h22: r = 8'hD8;
      8'h35: r = 8'hD9;  8'h1A: r = 8'hDA;
      8'h16: r = shifted ? 8'hA1 : 8'hB1;
      8'h1E: r = shifted ? 8'hC0 : 8'hB2;
      8'h26: r = shifted ? 8'hA3 : 8'hB3;
      8'h25: r = shifted ? 8'hA4 : 8'hB4;
      8'h2E: r = shifted ? 8'hA5 : 8'hB5;
      8'h36: r = shifted ? 8'hDE : 8'hB6;
      8'h3D: r = shifted ? 8'hA6 : 8'hB7;
      8'h3E: r = shifted ? 8'hAA : 8'hB8;
      8'h46: r = shifted ? 8'hA8 : 8'hB9;
      8'h45: r = shifted ? 8'hA9 : 8'hB0;
      8'h0E: r = shifted ? 8'hFE : 8'hE0;
      8'h4E: r = shifted ? 8'hDF : 8'hAD;
      8'h55: r = shifted ? 8'hAB : 8'hBD;
      8'h54: r = shifted ? 8'hFB : 8'hDB;
      8'h5B: r = shifted ? 8'hFD : 8'hDD;
      8'h5D: r = shifted ? 8'hFC : 8'hDC;
      8'h4C: r = shifted ? 8'hBA : 8'hBB;
      8'h52: r = shifted ? 8'hA2 : 8'hA7;
      8'h41: r = shifted ? 8'hBC : 8'hAC;
      8'h49: r = shifted ? 8'hBE : 8'hAE;
      8'h4A: r = shifted ? 8'hBF : 8'hAF;
      8'h29: r = 8'hA0;
      8'h5A: r = 8'h8D;
      8'h76: r = 8'h9B;
      8'h66: r = 8'hDF;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Two-flop synchronisers; the PS/2 lines idle high.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      din_meta <= 1'b1;
      din_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      din_meta <= ps2_din;
      din_sync <= din_meta;
    end
  end

  // Glitch filter on the PS/2 clock; a filtered falling edge raises sample for one cycle.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= {FW{1'b0}};
      sample   <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (clk_sync == clk_filt) begin
        filt_cnt <= {FW{1'b0}};
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync;
        filt_cnt <= {FW{1'b0}};
        sample   <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + {{(FW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Frame receiver with inter-edge timeout.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      idle_cnt   <= {TW{1'b0}};
      byte_valid <= 1'b0;
      rx_byte    <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample) begin
        idle_cnt <= {TW{1'b0}};
        case (state)
          IDLE: begin
            if (!din_sync) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shreg <= {din_sync, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_bit <= din_sync;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (din_sync && odd_parity_ok(shreg, par_bit)) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        idle_cnt <= {TW{1'b0}};
      end else if (idle_cnt == TIMEOUT_LAST) begin
        state     <= IDLE;
        idle_cnt  <= {TW{1'b0}};
        frame_err <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + {{(TW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Translation of the received byte, including Ctrl folding of 0x40-0x5F.
  always_comb begin
    xl       = xlat(rx_byte, shift);
    key_hit  = 1'b0;
    key_raw  = 7'h00;
    key_val  = 7'h00;
    key_take = 1'b0;
    if (ext) begin
      if (rx_byte == 8'h5A) begin
        key_hit = 1'b1;
        key_raw = 7'h0D;
      end else begin
        key_hit = 1'b0;
        key_raw = 7'h00;
      end
    end else begin
      key_hit = xl[7];
      key_raw = xl[6:0];
    end
    if (ctrl && key_raw[6:5] == 2'b10) key_val = key_raw & 7'h1F;
    else key_val = key_raw;
    if (byte_valid && !brk && rx_byte != 8'hE0 && rx_byte != 8'hF0) key_take = key_hit;
    else key_take = 1'b0;
  end

  // Modifier/prefix tracking, request pulses and the one-entry key buffer.
  always_ff @(posedge clk14 or posedge reset) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      shift       <= 1'b0;
      ctrl        <= 1'b0;
      key_data    <= 7'h00;
      key_strobe  <= 1'b0;
      key_overrun <= 1'b0;
      reset_req   <= 1'b0;
      cls_req     <= 1'b0;
    end else begin
      reset_req <= 1'b0;
      cls_req   <= 1'b0;
      if (key_take) begin
        key_data    <= key_val;
        key_strobe  <= 1'b1;
        key_overrun <= key_strobe & ~key_ack;
      end else if (key_ack) begin
        key_strobe  <= 1'b0;
        key_overrun <= 1'b0;
      end
      if (byte_valid) begin
        case (rx_byte)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (brk) begin
              if (!ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) shift <= 1'b0;
              if (rx_byte == 8'h14) ctrl <= 1'b0;
            end else begin
              if (!ext && (rx_byte == 8'h12 || rx_byte == 8'h59)) shift <= 1'b1;
              if (rx_byte == 8'h14) ctrl <= 1'b1;
              if (!ext && rx_byte == 8'h07) reset_req <= 1'b1;
              if (!ext && rx_byte == 8'h05) cls_req <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_apple1_kbd.md
# ps2_apple1_kbd

PS/2 keyboard front end for the Apple-1 core, placed between the `user_io` PS/2 keyboard outputs (`ps2_kbd_clk`, `ps2_kbd_data`) and the Apple-1 keyboard PIA port. It receives PS/2 set-2 frames and tracks make/break, E0 prefix, Shift and Ctrl state. It translates make codes into 7-bit upper-case Apple-1 ASCII, held in a one-entry key buffer with a sticky strobe. It also emits one-cycle reset and clear-screen requests from dedicated keys.

## Interface
- FILTER_LEN, 8: clk14 cycles the synchronised PS/2 clock must be stable before an edge is accepted.
- TIMEOUT, 14318: idle clk14 cycles (about 1 ms) between accepted edges after which a partial frame is discarded.
- clk14  in  1  14.31818 MHz system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from user_io; asynchronous.
- ps2_din  in  1  PS/2 data from user_io; asynchronous.
- key_ack  in  1  one-cycle pulse when the PIA keyboard data register is read; clears key_strobe.
- key_data  out  7  last translated ASCII key.
- key_strobe  out  1  high while key_data is unread.
- key_overrun  out  1  set when a key replaces an unread key; cleared by key_ack.
- reset_req  out  1  one-cycle pulse on an F12 make.
- cls_req  out  1  one-cycle pulse on an F1 make.
- frame_err  out  1  one-cycle pulse on a bad start, parity, stop or timeout.

## Operation
- Input conditioning:
  - ps2_clk and ps2_din each pass through 2 flip-flops.
  - The filtered clock changes state only after the synchronised clock holds a new value for FILTER_LEN consecutive cycles.
  - A falling edge of the filtered clock is a sample event. Data is sampled from the synchronised ps2_din on that cycle.
- Receiver FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample with data 0, go to DATA with bit count 0. A sample with data 1 pulses frame_err and stays in IDLE.
  - DATA: shift 8 bits in LSB first; go to PARITY after bit 7.
  - PARITY: store the parity bit.
  - STOP: always returns to IDLE. If stop = 1 and the frame has odd parity over data plus parity bit, emit byte_valid for 1 cycle. Otherwise pulse frame_err.
  - Idle counter: cleared on every sample and counts while not in IDLE. On reaching TIMEOUT, return to IDLE and pulse frame_err.
- Decoder (acts on byte_valid):
  - E0 sets ext. F0 sets brk. Neither changes any output.
  - Any other code clears ext and brk after being processed.
  - Break of 12 or 59 clears shift. Break of 14 clears ctrl; E0 14 is treated as Ctrl too. All other breaks are ignored.
  - Make of 12 or 59 sets shift. Make of 14 sets ctrl.
  - Make of 07 (non-extended) pulses reset_req. Make of 05 pulses cls_req.
  - Extended makes: only E0 5A is translated (to 0x0D). All others are ignored.
  - Translation, US layout, upper case only:
    - A–Z map to 0x41–0x5A.
    - Digits and the punctuation keys ` - = [ ] \ ; ' , . / map to their ASCII codes, and to the shifted US symbols when shift is set.
    - Space maps to 0x20, Enter (5A) to 0x0D, Esc (76) to 0x1B, Backspace (66) to 0x5F.
    - With ctrl set, codes 0x40–0x5F are ANDed with 0x1F.
    - Codes with no mapping produce no key.
- Key buffer:
  - A translated key loads key_data and sets key_strobe.
  - If key_strobe was already 1 when the key loads, key_overrun is set.
  - key_ack clears key_strobe and key_overrun.
  - If key_ack and a new key arrive in the same cycle, the new key wins: key_strobe = 1 and key_overrun = 0.
- Reset: the FSM returns to IDLE; counters, shift, ctrl, ext and brk clear. Reset mid-frame discards the partial frame.

## Timing
- Reset values: key_data = 0x00; key_strobe, key_overrun, reset_req, cls_req and frame_err all 0.
- Raw ps2_clk fall to sample event: 2 + FILTER_LEN cycles.
- Stop-bit sample at cycle N:
  - byte_valid is registered at N+1.
  - key_data, key_strobe, reset_req and cls_req update at N+2.
  - frame_err (parity/stop error) asserts at N+1.
- key_ack at cycle M: key_strobe = 0 at M+1.
- All outputs are registered. Request and error outputs are exactly 1 cycle wide.

## Test plan
- Frame 1C followed by F0 1C, 60 µs bit period → key_data = 0x41 and key_strobe = 1 after the first frame; the break causes no further change; key_ack clears key_strobe.
- Sequence 12, 1E, F0 1E, F0 12, 1E → keys 0x40 ('@') then 0x32 ('2'); key_overrun = 1 after the second key with no ack in between.
- Sequence 14, 34 → key_data = 0x07; then F0 14, 34 → key_data = 0x47.
- Frame 1C with even parity → frame_err pulses once and key_strobe stays 0. Then drive 4 bits, idle 2 ms, send a valid 29 → one timeout frame_err, then key_data = 0x20.
- Make 07 → reset_req high for exactly 1 cycle. E0 07 → no pulse. 05 → one cls_req pulse. E0 5A → key_data = 0x0D.
- key_ack on the same cycle a new key loads → key_strobe = 1 and key_overrun = 0. Assert reset mid-frame → all outputs at their reset values, and the next full frame decodes correctly.
